line_scan_scheduler: RTL and testbench
======================================

Name: line_scan_scheduler

Overview:
- Sequences the existing combinational pixel_on_line comparator over a small table of velocity-arrow line segments, one segment per clock.
- Answers "is pixel (x,y) on any arrow?" for the renderer.
- Sits between the fluid-state writer, which loads segments, and the pixel pipeline, which issues pixel queries and consumes hit results.
- All coordinates and lengths are Q16.16 signed fixed point.

Parameters:
- NUM_LINES, 16, table depth (≥1).
- LINE_WIDTH_SQR, 100, passed through to pixel_on_line.
- IDX_W, $clog2(NUM_LINES), index width (derived localparam).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- wr_valid  in  1  segment write request.
- wr_ready  out  1  table writable.
- wr_idx  in  IDX_W  table slot.
- wr_x0, wr_y0  in  32  segment origin.
- wr_xn, wr_yn  in  32  unit direction.
- wr_mag  in  32  segment length.
- cfg_count  in  IDX_W+1  number of active entries, 0..NUM_LINES.
- px_valid  in  1  pixel query valid.
- px_ready  out  1  query accepted.
- px_x, px_y  in  32  pixel coordinate.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_on_line  out  1  hit flag.
- res_line_idx  out  IDX_W  index of the reported hit entry. 0 when there is no hit.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all table entries are cleared to 0.
  - res_valid=0, res_on_line=0, res_line_idx=0, latched pixel=0, scan index=0.
  - A reset mid-scan aborts the scan silently; no result is produced.
- Outputs: wr_ready = px_ready = (state==IDLE). busy is high in SCAN and DONE.
- Table write:
  - Accepted on wr_valid && wr_ready; updates the slot at the next edge.
  - wr_idx ≥ NUM_LINES is dropped, with no side effects.
  - If a write and a pixel query are accepted in the same cycle, both take effect. The scan starts the next cycle and sees the new entry.
- Query acceptance:
  - In IDLE, px_valid && px_ready latches px_x, px_y and cnt = min(cfg_count, NUM_LINES).
  - cfg_count is sampled only at acceptance.
- States:
  - IDLE: on accept, if cnt==0 go to DONE with res_on_line=0, res_line_idx=0. Otherwise go to SCAN with i=0.
  - SCAN: drive pixel_on_line with the latched pixel and table[i]; register its on_line at the edge.
    - If on_line=1, go to DONE with res_on_line=1, res_line_idx=i (early exit).
    - Else if i==cnt-1, go to DONE with res_on_line=0, res_line_idx=0.
    - Else i=i+1.
  - DONE: res_valid=1. res_on_line and res_line_idx are held stable until res_ready. On res_valid && res_ready, go to IDLE and clear res_valid.
- Latency:
  - Query accepted at edge t. Entry i is evaluated in cycle t+1+i. res_valid rises at t+1+k, where k = entries evaluated (hit index+1, or cnt).
  - cnt==0 gives res_valid at t+1.
- Throughput: one query in flight. Back-to-back queries need a minimum of k+2 cycles each, because IDLE is re-entered before the next accept.
- Arithmetic: no arithmetic in this block beyond index compare and clamp. The index counter never wraps past cnt-1.

Optional Feature:
- Macro: LINE_SCAN_FULL_SCAN_EN.
- Defined:
  - Early exit is disabled; all cnt entries are always scanned, so latency is fixed at cnt+1.
  - res_on_line is the OR of all hits; res_line_idx is the highest hitting index.
  - The hit flag accumulates in a sticky register that is cleared at acceptance.
- Undefined: early exit on the first (lowest-index) hit, as in Behaviour.
- Ports are identical in both builds.

Decomposition:
- Shared package line_scan_pkg:
  - typedef fix_t (logic signed [31:0], Q16.16).
  - constant FIX_ONE = 32'h0001_0000.
  - packed struct line_seg_t {x0, y0, xn, yn, mag}.
  - enum sched_state_t {IDLE, SCAN, DONE}.
- Sub-module: the existing pixel_on_line, instantiated once and fed by a table-read mux. No other sub-module; the table is a register array inside this block.

Test Plan:
- Reset mid-scan:
  - Load 4 entries, cnt=4, issue a query, assert rst_n=0 during SCAN.
  - Expect res_valid=0 and state IDLE immediately.
  - Expect every entry to read as zero afterwards, so a query with cfg_count=1 misses.
- Single hit:
  - Entry 0: x0=0, y0=0, xn=FIX_ONE, yn=0, mag=20.0; cfg_count=1; query (10.0, 0).
  - Expect res_on_line=1, res_line_idx=0, res_valid at t+2.
- Misses:
  - Same entry; query (30.0, 0), which is beyond mag → res_on_line=0.
  - Query (10.0, 50.0), which is off-axis → res_on_line=0.
  - Both results arrive at t+2.
- Early exit and full scan:
  - Load 8 entries; only entries 3 and 6 pass through (10,10); cfg_count=8.
  - Default build: res_line_idx=3, res_valid at t+5.
  - With LINE_SCAN_FULL_SCAN_EN: res_line_idx=6, res_valid at t+9.
- Boundary and backpressure:
  - cfg_count=0 → miss at t+1.
  - cfg_count=NUM_LINES+3 → clamped; exactly NUM_LINES evaluations.
  - Hold res_ready=0 for 5 cycles → outputs stable, px_ready=0, wr_ready=0.
- Write rules:
  - Write with wr_idx=NUM_LINES → ignored.
  - Write attempted during SCAN → wr_ready=0, table unchanged.
  - Write and query accepted in the same cycle → the scan uses the new entry.

Source files
------------

// File: rtl/line_scan_pkg.sv
// Shared types for the line-scan scheduler: Q16.16 fixed point, segment record, FSM states.
package line_scan_pkg;

  typedef logic signed [31:0] fix_t;

  localparam fix_t FIX_ONE = 32'h0001_0000;

  typedef struct packed {
    fix_t x0;
    fix_t y0;
    fix_t xn;
    fix_t yn;
    fix_t mag;
  } line_seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/pixel_on_line.sv
// Combinational test of whether a pixel lies within sqrt(LINE_WIDTH_SQR) pixels of a
// segment that starts at (x0,y0), runs along unit vector (xn,yn) and is mag long.
module pixel_on_line
  import line_scan_pkg::*;
#(
  parameter int LINE_WIDTH_SQR = 100
) (
  input  fix_t      px,
  input  fix_t      py,
  input  line_seg_t seg,
  output logic      on_line
);

  logic signed [65:0] dx, dy, xn_w, yn_w, mag_w;
  logic signed [65:0] proj_full, perp_full, proj, perp, perp_abs;
  logic        [47:0] perp_sq;
  logic               perp_ok;

  // Along-axis projection and perpendicular offset, both brought back to Q16.16.
  // A segment with non-positive length is treated as empty so cleared slots never match.
  always_comb begin
    dx        = 66'(px) - 66'(seg.x0);
    dy        = 66'(py) - 66'(seg.y0);
    xn_w      = 66'(seg.xn);
    yn_w      = 66'(seg.yn);
    mag_w     = 66'(seg.mag);
    proj_full = dx * xn_w + dy * yn_w;
    perp_full = dx * yn_w - dy * xn_w;
    proj      = proj_full >>> 16;
    perp      = perp_full >>> 16;
    perp_abs  = perp[65] ? -perp : perp;
    perp_sq   = 48'(perp_abs[23:0]) * 48'(perp_abs[23:0]);
    perp_ok   = (perp_abs < 66'sd16777216) && (perp_sq <= (48'(LINE_WIDTH_SQR) << 32));
    on_line   = (seg.mag > 0) && !proj[65] && (proj <= mag_w) && perp_ok;
  end

endmodule

// File: rtl/line_scan_scheduler.sv
// Scans a register table of arrow segments one per clock to answer pixel hit queries.
// Define LINE_SCAN_FULL_SCAN_EN to scan every active entry and report the highest hit.
module line_scan_scheduler
  import line_scan_pkg::*;
#(
  parameter int  NUM_LINES      = 16,
  parameter int  LINE_WIDTH_SQR = 100,
  localparam int IDX_W          = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_x0,
  input  logic [31:0]      wr_y0,
  input  logic [31:0]      wr_xn,
  input  logic [31:0]      wr_yn,
  input  logic [31:0]      wr_mag,
  input  logic [IDX_W:0]   cfg_count,
  input  logic             px_valid,
  output logic             px_ready,
  input  logic [31:0]      px_x,
  input  logic [31:0]      px_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_on_line,
  output logic [IDX_W-1:0] res_line_idx,
  output logic             busy
);

  localparam logic [IDX_W:0] NUM_LINES_W = (IDX_W + 1)'(NUM_LINES);

  sched_state_t     state_q, state_d;
  line_seg_t        seg_table [NUM_LINES];
  line_seg_t        cur_seg;
  fix_t             px_q, py_q;
  logic [IDX_W:0]   cnt_q, cnt_clamped;
  logic [IDX_W-1:0] scan_idx_q, res_idx_q;
  logic             res_on_line_q;
  logic             hit, last_entry, px_accept, wr_accept;

  assign cnt_clamped = (cfg_count > NUM_LINES_W) ? NUM_LINES_W : cfg_count;
  assign px_accept   = px_valid && px_ready;
  assign wr_accept   = wr_valid && wr_ready && ({1'b0, wr_idx} < NUM_LINES_W);
  assign last_entry  = ({1'b0, scan_idx_q} == (cnt_q - 1'b1));
  assign cur_seg     = seg_table[scan_idx_q];

  pixel_on_line #(
    .LINE_WIDTH_SQR(LINE_WIDTH_SQR)
  ) u_pixel_on_line (
    .px     (px_q),
    .py     (py_q),
    .seg    (cur_seg),
    .on_line(hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (px_accept) state_d = (cnt_clamped == '0) ? DONE : SCAN;
`ifdef LINE_SCAN_FULL_SCAN_EN
      SCAN: if (last_entry) state_d = DONE;
`else
      SCAN: if (hit || last_entry) state_d = DONE;
`endif
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready     = (state_q == IDLE);
    px_ready     = (state_q == IDLE);
    busy         = (state_q != IDLE);
    res_valid    = (state_q == DONE);
    res_on_line  = res_on_line_q;
    res_line_idx = res_idx_q;
  end

  // A write accepted alongside a query lands before the first scan cycle reads the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) seg_table[i] <= '0;
    end else if (wr_accept) begin
      seg_table[wr_idx] <= '{x0: wr_x0, y0: wr_y0, xn: wr_xn, yn: wr_yn, mag: wr_mag};
    end
  end

  // The hit flag is set-only during a scan, so in full-scan mode it is the OR of all hits
  // and the index naturally ends on the highest hitting entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q          <= '0;
      py_q          <= '0;
      cnt_q         <= '0;
      scan_idx_q    <= '0;
      res_on_line_q <= 1'b0;
      res_idx_q     <= '0;
    end else if (px_accept) begin
      px_q          <= px_x;
      py_q          <= px_y;
      cnt_q         <= cnt_clamped;
      scan_idx_q    <= '0;
      res_on_line_q <= 1'b0;
      res_idx_q     <= '0;
    end else if (state_q == SCAN) begin
      if (hit) begin
        res_on_line_q <= 1'b1;
        res_idx_q     <= scan_idx_q;
      end
      if (!last_entry) scan_idx_q <= scan_idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_line_scan_scheduler.sv
// Scoreboard bench for line_scan_scheduler; expectations follow LINE_SCAN_FULL_SCAN_EN.
module tb_line_scan_scheduler;

  localparam int NL = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_idx = '0;
  logic [31:0]   wr_x0 = '0, wr_y0 = '0, wr_xn = '0, wr_yn = '0, wr_mag = '0;
  logic [IW:0]   cfg_count = '0;
  logic          px_valid = 1'b0;
  logic          px_ready;
  logic [31:0]   px_x = '0, px_y = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          res_on_line;
  logic [IW-1:0] res_line_idx;
  logic          busy;

  typedef struct {
    logic          on_line;
    logic [IW-1:0] idx;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cycle_cnt = 0;
  int   accept_cycle = 0;

  line_scan_scheduler #(.NUM_LINES(NL), .LINE_WIDTH_SQR(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_xn(wr_xn), .wr_yn(wr_yn), .wr_mag(wr_mag),
    .cfg_count(cfg_count),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_on_line(res_on_line), .res_line_idx(res_line_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [31:0] fx(input int v);
    return 32'(v <<< 16);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  task automatic setWrite(input int idx, input int x0, input int y0, input int mag);
    wr_valid = 1'b1;
    wr_idx   = IW'(idx);
    wr_x0    = fx(x0);
    wr_y0    = fx(y0);
    wr_xn    = 32'h0001_0000;
    wr_yn    = '0;
    wr_mag   = fx(mag);
  endtask

  task automatic loadSegment(input int idx, input int x0, input int y0, input int mag);
    setWrite(idx, x0, y0, mag);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Drives one query (and clears any write driven alongside it) through its accept edge.
  task automatic applyStimulus(input int x, input int y, input int cnt, input logic exp_on,
                               input int exp_idx, input int exp_lat, input bit push);
    exp_t e;
    px_x      = fx(x);
    px_y      = fx(y);
    cfg_count = (IW + 1)'(cnt);
    px_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept_cycle = cycle_cnt;
    px_valid = 1'b0;
    wr_valid = 1'b0;
    if (push) begin
      e.on_line = exp_on;
      e.idx     = IW'(exp_idx);
      e.lat     = exp_lat;
      sb.push_back(e);
    end
  endtask

  task automatic collectResult(input int hold);
    exp_t e;
    for (int n = 0; n < 200 && !res_valid; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    if (!res_valid) begin
      checkOutput("timeout", 64'(res_valid), 64'd1);
      res_ready = 1'b1;
      return;
    end
    checkOutput("on_line", 64'(res_on_line), 64'(e.on_line));
    checkOutput("line_idx", 64'(res_line_idx), 64'(e.idx));
    checkOutput("latency", 64'(cycle_cnt - accept_cycle + 1), 64'(e.lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", 64'(res_valid), 64'd1);
      checkOutput("hold_on_line", 64'(res_on_line), 64'(e.on_line));
      checkOutput("hold_idx", 64'(res_line_idx), 64'(e.idx));
      checkOutput("hold_px_ready", 64'(px_ready), 64'd0);
      checkOutput("hold_wr_ready", 64'(wr_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("back_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic exp_full;
    int   bp_idx, bp_lat;
`ifdef LINE_SCAN_FULL_SCAN_EN
    exp_full = 1'b1;
`else
    exp_full = 1'b0;
`endif
    bp_idx = exp_full ? 6 : 3;
    bp_lat = exp_full ? 9 : 5;

    repeat (2) @(negedge clk);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_on_line", 64'(res_on_line), 64'd0);
    checkOutput("rst_idx", 64'(res_line_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_px_ready", 64'(px_ready), 64'd1);
    checkOutput("idle_wr_ready", 64'(wr_ready), 64'd1);

    // Single hit and the two kinds of miss against one horizontal arrow.
    loadSegment(0, 0, 0, 20);
    applyStimulus(10, 0, 1, 1'b1, 0, 2, 1'b1);  collectResult(0);
    applyStimulus(30, 0, 1, 1'b0, 0, 2, 1'b1);  collectResult(0);
    applyStimulus(10, 50, 1, 1'b0, 0, 2, 1'b1); collectResult(0);

    // Eight entries, only 3 and 6 pass through (10,10).
    for (int k = 0; k < 8; k++) loadSegment(k, 0, (k == 3 || k == 6) ? 10 : 1000, 20);
    applyStimulus(10, 10, 8, 1'b1, bp_idx, bp_lat, 1'b1); collectResult(0);

    applyStimulus(10, 10, 0, 1'b0, 0, 1, 1'b1); collectResult(0);

    // Out-of-range slot write is dropped; oversized count clamps to NL evaluations.
    loadSegment(NL, 490, 500, 20);
    applyStimulus(500, 500, NL + 3, 1'b0, 0, NL + 1, 1'b1); collectResult(0);

    res_ready = 1'b0;
    applyStimulus(10, 10, 8, 1'b1, bp_idx, bp_lat, 1'b1); collectResult(5);

    // Write attempted mid-scan must be refused.
    applyStimulus(500, 500, NL, 1'b0, 0, NL + 1, 1'b1);
    setWrite(0, 490, 500, 20);
    checkOutput("wr_ready_scan", 64'(wr_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    collectResult(0);
    applyStimulus(500, 500, 1, 1'b0, 0, 2, 1'b1); collectResult(0);

    setWrite(0, 490, 500, 20);
    applyStimulus(500, 500, 1, 1'b1, 0, 2, 1'b1); collectResult(0);

    // Reset while scanning aborts without a result and clears the table.
    applyStimulus(10, 10, 8, 1'b0, 0, 0, 1'b0);
    checkOutput("scan_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_res_valid", 64'(res_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(500, 500, 1, 1'b0, 0, 2, 1'b1); collectResult(0);
    applyStimulus(10, 10, 8, 1'b0, 0, 9, 1'b1);   collectResult(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
